// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit sequencing register read, ALU and writeback.
// Latency: 2 states after DECODE for MOV imm, 4 for MOV reg and CMP, 5 for ADD/AND/MVN; illegal returns from DECODE.
// Backpressure: none; a start is accepted only while w=1, and s is ignored in all other states.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset (forces WAIT)
//   s               start strobe, level-sampled only in WAIT
//   opcode, op      decoded instruction fields, captured on the edge that leaves WAIT
//   w               high only in WAIT
//   nsel            one-hot register select: 001 Rm, 010 Rd, 100 Rn
//   vsel            one-hot writeback source: 0001 C, 0100 sximm8
//   loada, loadb    load A / B pipeline registers
//   asel, bsel      ALU operand selects (asel=1 zeroes A; bsel never driven high)
//   loadc, loads    load C register / status flags
//   write           register file write enable
//   illegal         high during DECODE of an unsupported encoding
module cpu_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       illegal
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_ALU       = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;

  localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
  localparam logic [4:0] OP_MOV_REG = 5'b110_00;
  localparam logic [4:0] OP_CMP     = 5'b101_01;
  localparam logic [4:0] OP_MVN     = 5'b101_11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  localparam logic [3:0] VSEL_NONE = 4'b0000;
  localparam logic [3:0] VSEL_C    = 4'b0001;
  localparam logic [3:0] VSEL_IMM  = 4'b0100;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [4:0] ir;          // captured {opcode, op} for the instruction in flight
  logic       alu_class;   // 101_xx: two-operand ALU instructions

  assign alu_class = (ir[4:2] == 3'b101);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= 5'b0;
    end else begin
      state <= next_state;
      // Fields are frozen for the whole instruction; decoder changes after
      // the start edge must not alter the sequence.
      if (state == S_WAIT && s) begin
        ir <= {opcode, op};
      end
    end
  end

  always_comb begin
    next_state = S_WAIT;
    case (state)
      S_WAIT:      next_state = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (ir == OP_MOV_IMM)      next_state = S_WRITE_IMM;
        else if (ir == OP_MOV_REG) next_state = S_GET_B;
        else if (alu_class)        next_state = S_GET_A;
        else                       next_state = S_WAIT;
      end
      S_WRITE_IMM: next_state = S_WAIT;
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_ALU;
      // CMP only updates flags, so it skips the writeback state.
      S_ALU:       next_state = (ir == OP_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  always_comb begin
    w       = 1'b0;
    nsel    = NSEL_NONE;
    vsel    = VSEL_NONE;
    loada   = 1'b0;
    loadb   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    write   = 1'b0;
    illegal = 1'b0;
    case (state)
      S_WAIT: w = 1'b1;
      S_DECODE: begin
        illegal = !((ir == OP_MOV_IMM) || (ir == OP_MOV_REG) || alu_class);
      end
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        // MOV reg and MVN pass only the shifted B operand, so A is forced to 0.
        asel  = (ir == OP_MOV_REG) || (ir == OP_MVN);
        loads = (ir == OP_CMP);
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       loada, loadb, asel, bsel, loadc, loads, write, illegal;

  int compared = 0;
  int mismatched = 0;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .write(write), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: [15]w [14:12]nsel [11:8]vsel [7]loada [6]loadb [5]asel
  //                [4]bsel [3]loadc [2]loads [1]write [0]illegal
  localparam logic [15:0] V_WAIT     = 16'h8000;
  localparam logic [15:0] V_DEC      = 16'h0000;
  localparam logic [15:0] V_ILL      = 16'h0001;
  localparam logic [15:0] V_WIMM     = 16'h4402; // nsel=100 vsel=0100 write
  localparam logic [15:0] V_GETA     = 16'h4080; // nsel=100 loada
  localparam logic [15:0] V_GETB     = 16'h1040; // nsel=001 loadb
  localparam logic [15:0] V_ALU      = 16'h0008; // loadc
  localparam logic [15:0] V_ALU_ASEL = 16'h0028; // loadc asel
  localparam logic [15:0] V_ALU_CMP  = 16'h000C; // loadc loads
  localparam logic [15:0] V_WREG     = 16'h2102; // nsel=010 vsel=0001 write

  logic [15:0] obs;
  assign obs = {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal};

  logic write_seen;

  task automatic check(input string tag, input logic [15:0] expected);
    compared++;
    assert (obs === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expected);
    end
    compared++;
    assert (!(write === 1'b1 && loadc === 1'b1)) else begin
      mismatched++;
      $error("FAIL %s_write_loadc_overlap: observed write=%b loadc=%b expected not both 1", tag, write, loadc);
    end
  endtask

  // Advance one edge and let outputs settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    s      = 1'b1;
    opcode = 3'b110;
    op     = 2'b10;

    // Reset held 2 cycles with s=1
    step(); check("reset_1", V_WAIT);
    step(); check("reset_2", V_WAIT);
    reset = 1'b0; s = 1'b0;
    step(); check("idle_1", V_WAIT);
    step(); check("idle_2", V_WAIT);

    // MOV Rn,#imm8
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    step(); check("movi_decode", V_DEC);
    s = 1'b0;
    step(); check("movi_write", V_WIMM);
    step(); check("movi_done", V_WAIT);

    // ADD
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    step(); check("add_decode", V_DEC);
    s = 1'b0;
    step(); check("add_get_a", V_GETA);
    step(); check("add_get_b", V_GETB);
    step(); check("add_alu", V_ALU);
    step(); check("add_write", V_WREG);
    step(); check("add_done", V_WAIT);

    // CMP: flags only, no writeback
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    step(); check("cmp_decode", V_DEC);
    s = 1'b0;
    step(); check("cmp_get_a", V_GETA);
    step(); check("cmp_get_b", V_GETB);
    step(); check("cmp_alu", V_ALU_CMP);
    step(); check("cmp_done", V_WAIT);

    // AND behaves like ADD at the control level
    opcode = 3'b101; op = 2'b10; s = 1'b1;
    step(); check("and_decode", V_DEC);
    s = 1'b0;
    step(); check("and_get_a", V_GETA);
    step(); check("and_get_b", V_GETB);
    step(); check("and_alu", V_ALU);
    step(); check("and_write", V_WREG);
    step(); check("and_done", V_WAIT);

    // MVN, then a back-to-back MOV reg with s held through completion
    opcode = 3'b101; op = 2'b11; s = 1'b1;
    step(); check("mvn_decode", V_DEC);
    s = 1'b0;
    step(); check("mvn_get_a", V_GETA);
    step(); check("mvn_get_b", V_GETB);
    step(); check("mvn_alu", V_ALU_ASEL);
    step(); check("mvn_write", V_WREG);
    opcode = 3'b110; op = 2'b00; s = 1'b1;
    step(); check("b2b_wait_pulse", V_WAIT);
    step(); check("movr_decode", V_DEC);
    // Decoder moves on; captured fields must still drive the sequence.
    opcode = 3'b111; s = 1'b0;
    step(); check("movr_get_b", V_GETB);
    step(); check("movr_alu", V_ALU_ASEL);
    step(); check("movr_write", V_WREG);
    step(); check("movr_done", V_WAIT);

    // Illegal encodings
    opcode = 3'b111; op = 2'b00; s = 1'b1;
    step(); check("ill_decode", V_ILL);
    s = 1'b0;
    step(); check("ill_done", V_WAIT);
    opcode = 3'b110; op = 2'b01; s = 1'b1;
    step(); check("ill2_decode", V_ILL);
    s = 1'b0;
    step(); check("ill2_done", V_WAIT);

    // Reset during GET_B of ADD aborts with no write
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    step(); check("abort_decode", V_DEC);
    s = 1'b0;
    step(); check("abort_get_a", V_GETA);
    step(); check("abort_get_b", V_GETB);
    reset = 1'b1;
    write_seen = 1'b0;
    step(); check("abort_reset", V_WAIT);
    write_seen = write_seen | write;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      write_seen = write_seen | write;
    end
    check("abort_idle", V_WAIT);
    compared++;
    assert (write_seen === 1'b0) else begin
      mismatched++;
      $error("FAIL abort_no_write: observed write_seen=%b expected 0", write_seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
